// File: rtl/alu_rs_pkg.sv
// Shared widths, the "no tag" encoding and ALU opcodes used by the ROB,
// the decoder and the ALU reservation station.
package alu_rs_pkg;

    localparam int RS_SIZE = 4;
    localparam int DATA_W  = 32;
    localparam int TAG_W   = 4;
    localparam int OP_W    = 4;

    // MSB set marks an operand as ready; the low bits are the ROB index.
    localparam logic [TAG_W-1:0] TAG_FREE = {1'b1, {(TAG_W-1){1'b0}}};

    localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
    localparam logic [OP_W-1:0] OP_SLL  = 4'd2;
    localparam logic [OP_W-1:0] OP_SLT  = 4'd3;
    localparam logic [OP_W-1:0] OP_SLTU = 4'd4;
    localparam logic [OP_W-1:0] OP_XOR  = 4'd5;
    localparam logic [OP_W-1:0] OP_SRL  = 4'd6;
    localparam logic [OP_W-1:0] OP_SRA  = 4'd7;
    localparam logic [OP_W-1:0] OP_OR   = 4'd8;
    localparam logic [OP_W-1:0] OP_AND  = 4'd9;

endpackage

// File: rtl/alu_rs_alu_unit.sv
// Purely combinational integer ALU: result = op(v1, v2), wrapping arithmetic.
module alu_unit
    import alu_rs_pkg::*;
#(
    parameter int DATA_W_P = DATA_W
) (
    input  logic [OP_W-1:0]     op,
    input  logic [DATA_W_P-1:0] v1,
    input  logic [DATA_W_P-1:0] v2,
    output logic [DATA_W_P-1:0] result
);

    logic [4:0] shamt;
    logic       lt_signed;
    logic       lt_unsigned;

    assign shamt       = v2[4:0];
    assign lt_signed   = $signed(v1) < $signed(v2);
    assign lt_unsigned = v1 < v2;

    // Opcode decode; anything unlisted produces zero.
    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = v1 + v2;
            OP_SUB:  result = v1 - v2;
            OP_SLL:  result = v1 << shamt;
            OP_SLT:  result = {{(DATA_W_P-1){1'b0}}, lt_signed};
            OP_SLTU: result = {{(DATA_W_P-1){1'b0}}, lt_unsigned};
            OP_XOR:  result = v1 ^ v2;
            OP_SRL:  result = v1 >> shamt;
            OP_SRA:  result = $signed(v1) >>> shamt;
            OP_OR:   result = v1 | v2;
            OP_AND:  result = v1 & v2;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station plus ALU CDB driver.
//
// Insert handshake: the decoder presents in_valid with the renamed op; the
// op is accepted on a posedge where in_valid && rs_free. When rs_free is low
// nothing changes and the decoder must keep in_valid and its payload stable.
//
// Operands wake up from either CDB; the lowest-index entry with both
// operands ready issues into the ALU and its result is registered onto the
// ALU CDB, so a broadcast is visible for the cycle after the issue edge.
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int RS_SIZE_P = RS_SIZE,
    parameter int DATA_W_P  = DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [OP_W-1:0]     in_op,
    input  logic [TAG_W-1:0]    in_q1,
    input  logic [DATA_W_P-1:0] in_v1,
    input  logic [TAG_W-1:0]    in_q2,
    input  logic [DATA_W_P-1:0] in_v2,
    input  logic [TAG_W-1:0]    in_dest,
    output logic                rs_free,
    input  logic                lsb_cdb_valid,
    input  logic [TAG_W-1:0]    lsb_cdb_tag,
    input  logic [DATA_W_P-1:0] lsb_cdb_data,
    output logic                alu_cdb_valid,
    output logic [TAG_W-1:0]    alu_cdb_tag,
    output logic [DATA_W_P-1:0] alu_cdb_data
);

    localparam int IDX_W = (RS_SIZE_P > 1) ? $clog2(RS_SIZE_P) : 1;

    // Station entries.
    logic [RS_SIZE_P-1:0] busy_q, busy_d;
    logic [OP_W-1:0]      op_q   [RS_SIZE_P];
    logic [OP_W-1:0]      op_d   [RS_SIZE_P];
    logic [TAG_W-1:0]     q1_q   [RS_SIZE_P];
    logic [TAG_W-1:0]     q1_d   [RS_SIZE_P];
    logic [DATA_W_P-1:0]  v1_q   [RS_SIZE_P];
    logic [DATA_W_P-1:0]  v1_d   [RS_SIZE_P];
    logic [TAG_W-1:0]     q2_q   [RS_SIZE_P];
    logic [TAG_W-1:0]     q2_d   [RS_SIZE_P];
    logic [DATA_W_P-1:0]  v2_q   [RS_SIZE_P];
    logic [DATA_W_P-1:0]  v2_d   [RS_SIZE_P];
    logic [TAG_W-1:0]     dest_q [RS_SIZE_P];
    logic [TAG_W-1:0]     dest_d [RS_SIZE_P];

    // Registered ALU CDB.
    logic                 alu_cdb_valid_q, alu_cdb_valid_d;
    logic [TAG_W-1:0]     alu_cdb_tag_q, alu_cdb_tag_d;
    logic [DATA_W_P-1:0]  alu_cdb_data_q, alu_cdb_data_d;

    logic                 sel_valid;
    logic [IDX_W-1:0]     sel_idx;
    logic                 free_valid;
    logic [IDX_W-1:0]     free_idx;
    logic                 do_insert;
    logic [TAG_W-1:0]     ins_q1, ins_q2;
    logic [DATA_W_P-1:0]  ins_v1, ins_v2;
    logic [DATA_W_P-1:0]  alu_result;

    // Priority encoders on registered state: lowest ready entry and lowest empty slot.
    always_comb begin
        sel_valid  = 1'b0;
        sel_idx    = '0;
        free_valid = 1'b0;
        free_idx   = '0;
        for (int i = RS_SIZE_P - 1; i >= 0; i--) begin
            if (busy_q[i] && (q1_q[i] == TAG_FREE) && (q2_q[i] == TAG_FREE)) begin
                sel_valid = 1'b1;
                sel_idx   = IDX_W'(i);
            end
            if (!busy_q[i]) begin
                free_valid = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    assign rs_free   = free_valid;
    assign do_insert = in_valid && free_valid;

    // Same-cycle forwarding for the incoming operands; TAG_FREE never matches.
    always_comb begin
        ins_q1 = in_q1;
        ins_v1 = in_v1;
        ins_q2 = in_q2;
        ins_v2 = in_v2;
        if (in_q1 != TAG_FREE) begin
            if (alu_cdb_valid_q && (alu_cdb_tag_q == in_q1)) begin
                ins_q1 = TAG_FREE;
                ins_v1 = alu_cdb_data_q;
            end else if (lsb_cdb_valid && (lsb_cdb_tag == in_q1)) begin
                ins_q1 = TAG_FREE;
                ins_v1 = lsb_cdb_data;
            end
        end
        if (in_q2 != TAG_FREE) begin
            if (alu_cdb_valid_q && (alu_cdb_tag_q == in_q2)) begin
                ins_q2 = TAG_FREE;
                ins_v2 = alu_cdb_data_q;
            end else if (lsb_cdb_valid && (lsb_cdb_tag == in_q2)) begin
                ins_q2 = TAG_FREE;
                ins_v2 = lsb_cdb_data;
            end
        end
    end

    alu_unit #(
        .DATA_W_P (DATA_W_P)
    ) u_alu (
        .op     (op_q[sel_idx]),
        .v1     (v1_q[sel_idx]),
        .v2     (v2_q[sel_idx]),
        .result (alu_result)
    );

    // Entry next state: wakeup, clear on issue, write on insert.
    always_comb begin
        busy_d = busy_q;
        op_d   = op_q;
        q1_d   = q1_q;
        v1_d   = v1_q;
        q2_d   = q2_q;
        v2_d   = v2_q;
        dest_d = dest_q;
        for (int i = 0; i < RS_SIZE_P; i++) begin
            if (busy_q[i] && (q1_q[i] != TAG_FREE)) begin
                if (alu_cdb_valid_q && (alu_cdb_tag_q == q1_q[i])) begin
                    q1_d[i] = TAG_FREE;
                    v1_d[i] = alu_cdb_data_q;
                end else if (lsb_cdb_valid && (lsb_cdb_tag == q1_q[i])) begin
                    q1_d[i] = TAG_FREE;
                    v1_d[i] = lsb_cdb_data;
                end
            end
            if (busy_q[i] && (q2_q[i] != TAG_FREE)) begin
                if (alu_cdb_valid_q && (alu_cdb_tag_q == q2_q[i])) begin
                    q2_d[i] = TAG_FREE;
                    v2_d[i] = alu_cdb_data_q;
                end else if (lsb_cdb_valid && (lsb_cdb_tag == q2_q[i])) begin
                    q2_d[i] = TAG_FREE;
                    v2_d[i] = lsb_cdb_data;
                end
            end
            if (sel_valid && (sel_idx == IDX_W'(i))) begin
                busy_d[i] = 1'b0;
            end
            // The insert slot is non-busy now, so it can never be the issuing entry.
            if (do_insert && (free_idx == IDX_W'(i))) begin
                busy_d[i] = 1'b1;
                op_d[i]   = in_op;
                q1_d[i]   = ins_q1;
                v1_d[i]   = ins_v1;
                q2_d[i]   = ins_q2;
                v2_d[i]   = ins_v2;
                dest_d[i] = in_dest;
            end
        end
    end

    // CDB next state: strobe follows selection, tag/data hold when idle.
    always_comb begin
        alu_cdb_valid_d = sel_valid;
        alu_cdb_tag_d   = alu_cdb_tag_q;
        alu_cdb_data_d  = alu_cdb_data_q;
        if (sel_valid) begin
            alu_cdb_tag_d  = dest_q[sel_idx];
            alu_cdb_data_d = alu_result;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q          <= '0;
            alu_cdb_valid_q <= 1'b0;
            alu_cdb_tag_q   <= TAG_FREE;
            alu_cdb_data_q  <= '0;
            for (int i = 0; i < RS_SIZE_P; i++) begin
                op_q[i]   <= '0;
                q1_q[i]   <= TAG_FREE;
                v1_q[i]   <= '0;
                q2_q[i]   <= TAG_FREE;
                v2_q[i]   <= '0;
                dest_q[i] <= TAG_FREE;
            end
        end else begin
            busy_q          <= busy_d;
            alu_cdb_valid_q <= alu_cdb_valid_d;
            alu_cdb_tag_q   <= alu_cdb_tag_d;
            alu_cdb_data_q  <= alu_cdb_data_d;
            for (int i = 0; i < RS_SIZE_P; i++) begin
                op_q[i]   <= op_d[i];
                q1_q[i]   <= q1_d[i];
                v1_q[i]   <= v1_d[i];
                q2_q[i]   <= q2_d[i];
                v2_q[i]   <= v2_d[i];
                dest_q[i] <= dest_d[i];
            end
        end
    end

    assign alu_cdb_valid = alu_cdb_valid_q;
    assign alu_cdb_tag   = alu_cdb_tag_q;
    assign alu_cdb_data  = alu_cdb_data_q;

endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs: latency, wakeup, forwarding, full station,
// ALU ops and asynchronous reset.
module tb_alu_rs;

    localparam logic [3:0] TF = 4'b1000;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [3:0]  in_op;
    logic [3:0]  in_q1;
    logic [31:0] in_v1;
    logic [3:0]  in_q2;
    logic [31:0] in_v2;
    logic [3:0]  in_dest;
    logic        rs_free;
    logic        lsb_cdb_valid;
    logic [3:0]  lsb_cdb_tag;
    logic [31:0] lsb_cdb_data;
    logic        alu_cdb_valid;
    logic [3:0]  alu_cdb_tag;
    logic [31:0] alu_cdb_data;

    int checks;
    int failures;

    alu_rs dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_op         (in_op),
        .in_q1         (in_q1),
        .in_v1         (in_v1),
        .in_q2         (in_q2),
        .in_v2         (in_v2),
        .in_dest       (in_dest),
        .rs_free       (rs_free),
        .lsb_cdb_valid (lsb_cdb_valid),
        .lsb_cdb_tag   (lsb_cdb_tag),
        .lsb_cdb_data  (lsb_cdb_data),
        .alu_cdb_valid (alu_cdb_valid),
        .alu_cdb_tag   (alu_cdb_tag),
        .alu_cdb_data  (alu_cdb_data)
    );

    // Clock: period 10, posedges at 5, 15, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance past the next posedge; outputs and new inputs settle at +1.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ins(input logic [3:0] op, input logic [3:0] q1, input logic [31:0] v1,
                             input logic [3:0] q2, input logic [31:0] v2, input logic [3:0] dest);
        in_valid = 1'b1;
        in_op    = op;
        in_q1    = q1;
        in_v1    = v1;
        in_q2    = q2;
        in_v2    = v2;
        in_dest  = dest;
    endtask

    task automatic idle_ins();
        in_valid = 1'b0;
        in_op    = 4'd0;
        in_q1    = TF;
        in_v1    = 32'd0;
        in_q2    = TF;
        in_v2    = 32'd0;
        in_dest  = 4'd0;
    endtask

    // Ready op: inserted at the first edge, broadcast after the second.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string tag);
        drive_ins(op, TF, a, TF, b, 4'd1);
        step();
        idle_ins();
        step();
        check({31'd0, alu_cdb_valid}, 32'd1, {tag, "_valid"});
        check(alu_cdb_data, exp, tag);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b0;
        lsb_cdb_valid = 1'b0;
        lsb_cdb_tag   = TF;
        lsb_cdb_data  = 32'd0;
        idle_ins();

        // Reset state.
        #12;
        check({31'd0, alu_cdb_valid}, 32'd0, "reset_valid");
        check({28'd0, alu_cdb_tag}, {28'd0, TF}, "reset_tag");
        check(alu_cdb_data, 32'd0, "reset_data");
        check({31'd0, rs_free}, 32'd1, "reset_rs_free");
        rst = 1'b1;
        step();

        // Ready ADD then dependent SUB on its tag.
        drive_ins(4'd0, TF, 32'd5, TF, 32'd7, 4'd2);
        step();
        check({31'd0, alu_cdb_valid}, 32'd0, "add_not_yet");
        drive_ins(4'd1, 4'd2, 32'd0, TF, 32'd3, 4'd3);
        step();
        check({31'd0, alu_cdb_valid}, 32'd1, "add_valid");
        check({28'd0, alu_cdb_tag}, 32'd2, "add_tag");
        check(alu_cdb_data, 32'd12, "add_data");
        idle_ins();
        step();
        check({31'd0, alu_cdb_valid}, 32'd0, "add_one_cycle");
        step();
        check({31'd0, alu_cdb_valid}, 32'd1, "sub_valid");
        check({28'd0, alu_cdb_tag}, 32'd3, "sub_tag");
        check(alu_cdb_data, 32'd9, "sub_data");
        step();
        check({31'd0, alu_cdb_valid}, 32'd0, "sub_one_cycle");
        check({31'd0, rs_free}, 32'd1, "chain_rs_free");

        // Same-cycle forwarding from the ALU CDB into a new entry.
        drive_ins(4'd5, TF, 32'h0000_00F0, TF, 32'h0000_000F, 4'd4);
        step();
        idle_ins();
        step();
        check({28'd0, alu_cdb_tag}, 32'd4, "xor_tag");
        check(alu_cdb_data, 32'h0000_00FF, "xor_data");
        drive_ins(4'd0, 4'd4, 32'd0, TF, 32'd1, 4'd5);
        step();
        idle_ins();
        check({31'd0, alu_cdb_valid}, 32'd0, "fwd_gap");
        step();
        check({31'd0, alu_cdb_valid}, 32'd1, "fwd_valid");
        check({28'd0, alu_cdb_tag}, 32'd5, "fwd_tag");
        check(alu_cdb_data, 32'h0000_0100, "fwd_data");
        step();

        // Fill all four entries waiting on tag 5.
        drive_ins(4'd0, 4'd5, 32'd0, TF, 32'd2, 4'd0);
        step();
        drive_ins(4'd1, 4'd5, 32'd0, TF, 32'd1, 4'd1);
        step();
        drive_ins(4'd2, 4'd5, 32'd0, TF, 32'd4, 4'd2);
        step();
        drive_ins(4'd8, 4'd5, 32'd0, TF, 32'd6, 4'd3);
        step();
        check({31'd0, rs_free}, 32'd0, "full_rs_free");
        // Fifth insert must be dropped.
        drive_ins(4'd0, TF, 32'd1, TF, 32'd1, 4'd7);
        step();
        idle_ins();
        check({31'd0, rs_free}, 32'd0, "full_still_full");
        check({31'd0, alu_cdb_valid}, 32'd0, "full_no_issue");
        lsb_cdb_valid = 1'b1;
        lsb_cdb_tag   = 4'd5;
        lsb_cdb_data  = 32'd1;
        step();
        lsb_cdb_valid = 1'b0;
        lsb_cdb_tag   = TF;
        lsb_cdb_data  = 32'd0;
        check({31'd0, alu_cdb_valid}, 32'd0, "wake_no_same_edge");
        step();
        check({28'd0, alu_cdb_tag}, 32'd0, "full_tag0");
        check(alu_cdb_data, 32'd3, "full_data0");
        check({31'd0, rs_free}, 32'd1, "full_free_after_issue");
        step();
        check({28'd0, alu_cdb_tag}, 32'd1, "full_tag1");
        check(alu_cdb_data, 32'd0, "full_data1");
        step();
        check({28'd0, alu_cdb_tag}, 32'd2, "full_tag2");
        check(alu_cdb_data, 32'd16, "full_data2");
        step();
        check({31'd0, alu_cdb_valid}, 32'd1, "full_valid3");
        check({28'd0, alu_cdb_tag}, 32'd3, "full_tag3");
        check(alu_cdb_data, 32'd7, "full_data3");
        step();
        check({31'd0, alu_cdb_valid}, 32'd0, "full_fifth_dropped");

        // ALU operations.
        run_op(4'd7, 32'h8000_0000, 32'd4, 32'hF800_0000, "op_sra");
        run_op(4'd3, 32'hFFFF_FFFF, 32'd1, 32'd1, "op_slt");
        run_op(4'd4, 32'hFFFF_FFFF, 32'd1, 32'd0, "op_sltu");
        run_op(4'd1, 32'd0, 32'd1, 32'hFFFF_FFFF, "op_sub_wrap");
        run_op(4'd15, 32'h1234_5678, 32'h1111_1111, 32'd0, "op_undef");
        run_op(4'd6, 32'h8000_0000, 32'd4, 32'h0800_0000, "op_srl");
        run_op(4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, "op_add_wrap");
        run_op(4'd9, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, "op_and");
        run_op(4'd2, 32'd1, 32'h0000_0025, 32'd32, "op_sll_shamt5");
        step();

        // Asynchronous reset with pending entries and a live broadcast.
        drive_ins(4'd0, 4'd6, 32'd0, TF, 32'd1, 4'd0);
        step();
        drive_ins(4'd0, 4'd6, 32'd0, TF, 32'd2, 4'd1);
        step();
        drive_ins(4'd0, TF, 32'd2, TF, 32'd3, 4'd2);
        step();
        idle_ins();
        step();
        check({31'd0, alu_cdb_valid}, 32'd1, "pre_reset_valid");
        check(alu_cdb_data, 32'd5, "pre_reset_data");
        #2;
        rst = 1'b0;
        #1;
        check({31'd0, alu_cdb_valid}, 32'd0, "async_reset_valid");
        check({28'd0, alu_cdb_tag}, {28'd0, TF}, "async_reset_tag");
        check({31'd0, rs_free}, 32'd1, "async_reset_rs_free");
        #2;
        rst = 1'b1;
        lsb_cdb_valid = 1'b1;
        lsb_cdb_tag   = 4'd6;
        lsb_cdb_data  = 32'd9;
        step();
        lsb_cdb_valid = 1'b0;
        lsb_cdb_tag   = TF;
        for (int k = 0; k < 6; k++) begin
            check({31'd0, alu_cdb_valid}, 32'd0, "post_reset_quiet");
            step();
        end
        check({31'd0, rs_free}, 32'd1, "post_reset_rs_free");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
